// File: rtl/alu_operand_collector.sv
// Receive-side operand collector: gathers OPA/OPB split across beats and issues one operation
// over a valid/ready handshake. Optional error counter enabled by ALU_COLL_ERRCNT_EN.
module alu_operand_collector #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CMD_WIDTH  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CE,
  input  logic [DATA_WIDTH-1:0] OPA,
  input  logic [DATA_WIDTH-1:0] OPB,
  input  logic                  CIN,
  input  logic                  MODE,
  input  logic [CMD_WIDTH-1:0]  CMD,
  input  logic [1:0]            INP_VALID,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic                  op_cin,
  output logic                  op_mode,
  output logic [CMD_WIDTH-1:0]  op_cmd,
  output logic                  ERR
`ifdef ALU_COLL_ERRCNT_EN
  ,
  input  logic                  err_count_clr,
  output logic [7:0]            err_count
`endif
);

  localparam int unsigned TmoWidth = $clog2(TIMEOUT + 1);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StIssue} state_e;

  state_e                state_q, state_d;
  logic [TmoWidth-1:0]   tmo_q, tmo_d;
  logic                  have_a_q, have_a_d;
  logic                  have_b_q, have_b_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  op_cin_q, op_cin_d;
  logic                  op_mode_q, op_mode_d;
  logic [CMD_WIDTH-1:0]  op_cmd_q, op_cmd_d;
  logic                  err_q, err_d;

  logic [1:0] need;
  logic [1:0] got;

  // Returns {need_b, need_a} for a command.
  function automatic logic [1:0] need_of(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    logic [1:0] n;
    n = 2'b11;
    if (mode) begin
      case (cmd)
        CMD_WIDTH'(4), CMD_WIDTH'(5): n = 2'b01;
        CMD_WIDTH'(6), CMD_WIDTH'(7): n = 2'b10;
        default:                      n = 2'b11;
      endcase
    end else begin
      case (cmd)
        CMD_WIDTH'(6), CMD_WIDTH'(8), CMD_WIDTH'(9):   n = 2'b01;
        CMD_WIDTH'(7), CMD_WIDTH'(10), CMD_WIDTH'(11): n = 2'b10;
        default:                                       n = 2'b11;
      endcase
    end
    return n;
  endfunction

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    have_a_d  = have_a_q;
    have_b_d  = have_b_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_cin_d  = op_cin_q;
    op_mode_d = op_mode_q;
    op_cmd_d  = op_cmd_q;
    err_d     = 1'b0;
    need      = 2'b11;
    got       = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (INP_VALID == 2'b00) begin
          err_d = 1'b1;
        end else begin
          op_cmd_d  = CMD;
          op_mode_d = MODE;
          op_cin_d  = CIN;
          op_a_d    = INP_VALID[0] ? OPA : '0;
          op_b_d    = INP_VALID[1] ? OPB : '0;
          have_a_d  = INP_VALID[0];
          have_b_d  = INP_VALID[1];
          need      = need_of(MODE, CMD);
          got       = INP_VALID;
          if ((need & ~got) == 2'b00) begin
            state_d = StIssue;
            tmo_d   = '0;
          end else begin
            state_d = StWait;
            tmo_d   = TmoWidth'(1);
          end
        end
      end
      StWait: begin
        if (INP_VALID[0]) begin
          op_a_d   = OPA;
          have_a_d = 1'b1;
        end
        if (INP_VALID[1]) begin
          op_b_d   = OPB;
          have_b_d = 1'b1;
        end
        need = need_of(op_mode_q, op_cmd_q);
        got  = {have_b_q | INP_VALID[1], have_a_q | INP_VALID[0]};
        // Completion is tested before the timeout so it wins a tie.
        if ((need & ~got) == 2'b00) begin
          state_d = StIssue;
          tmo_d   = '0;
        end else if (tmo_q == TmoLast) begin
          err_d    = 1'b1;
          state_d  = StIdle;
          tmo_d    = '0;
          have_a_d = 1'b0;
          have_b_d = 1'b0;
          op_a_d   = '0;
          op_b_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoWidth'(1);
        end
      end
      StIssue: begin
        if (op_ready) begin
          state_d  = StIdle;
          have_a_d = 1'b0;
          have_b_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      have_a_q  <= 1'b0;
      have_b_q  <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_cin_q  <= 1'b0;
      op_mode_q <= 1'b0;
      op_cmd_q  <= '0;
      err_q     <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      have_a_q  <= have_a_d;
      have_b_q  <= have_b_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_cin_q  <= op_cin_d;
      op_mode_q <= op_mode_d;
      op_cmd_q  <= op_cmd_d;
      err_q     <= err_d;
    end
  end

  assign op_valid = (state_q == StIssue);
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_cin   = op_cin_q;
  assign op_mode  = op_mode_q;
  assign op_cmd   = op_cmd_q;
  assign ERR      = err_q;

`ifdef ALU_COLL_ERRCNT_EN
  logic [7:0] err_count_q;

  // Counts alongside the ERR pulse; clear beats a simultaneous increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= 8'd0;
    end else if (CE) begin
      if (err_count_clr) begin
        err_count_q <= 8'd0;
      end else if (err_d && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign err_count = err_count_q;
`endif

endmodule
